// File: rtl/des_pkg.sv
// Shared widths, FSM encoding, output payload type and the DES IP / PC-1 tables.
// Table entries are 1-based bit positions where position 1 is the MSB of the source.
package des_pkg;

  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned BLK_W         = 64;
  localparam int unsigned KEY_W         = 64;
  localparam int unsigned RKEY_W        = 56;
  localparam int unsigned BYTES_PER_BLK = BLK_W / BYTE_W;
  localparam int unsigned CNT_W         = 4;
  localparam int unsigned BCNT_W        = 16;
  localparam int unsigned TBL_ENT_W     = 8;
  localparam int unsigned ST_W          = 2;

  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_FILL = 2'd1;
  localparam logic [ST_W-1:0] ST_FULL = 2'd2;

  // Output register payload handed to the decrypt core
  typedef struct packed {
    logic [BLK_W-1:0]  blk;
    logic [RKEY_W-1:0] key;
  } des_out_t;

  localparam logic [BLK_W*TBL_ENT_W-1:0] IP_TABLE = {
    8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18, 8'd10, 8'd2,
    8'd60, 8'd52, 8'd44, 8'd36, 8'd28, 8'd20, 8'd12, 8'd4,
    8'd62, 8'd54, 8'd46, 8'd38, 8'd30, 8'd22, 8'd14, 8'd6,
    8'd64, 8'd56, 8'd48, 8'd40, 8'd32, 8'd24, 8'd16, 8'd8,
    8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,  8'd1,
    8'd59, 8'd51, 8'd43, 8'd35, 8'd27, 8'd19, 8'd11, 8'd3,
    8'd61, 8'd53, 8'd45, 8'd37, 8'd29, 8'd21, 8'd13, 8'd5,
    8'd63, 8'd55, 8'd47, 8'd39, 8'd31, 8'd23, 8'd15, 8'd7
  };

  // Parity positions (8,16,..,64) never appear, so parity bits drop out
  localparam logic [RKEY_W*TBL_ENT_W-1:0] PC1_TABLE = {
    8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,
    8'd1,  8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18,
    8'd10, 8'd2,  8'd59, 8'd51, 8'd43, 8'd35, 8'd27,
    8'd19, 8'd11, 8'd3,  8'd60, 8'd52, 8'd44, 8'd36,
    8'd63, 8'd55, 8'd47, 8'd39, 8'd31, 8'd23, 8'd15,
    8'd7,  8'd62, 8'd54, 8'd46, 8'd38, 8'd30, 8'd22,
    8'd14, 8'd6,  8'd61, 8'd53, 8'd45, 8'd37, 8'd29,
    8'd21, 8'd13, 8'd5,  8'd28, 8'd20, 8'd12, 8'd4
  };

endpackage

// File: rtl/des_in_stage_if.sv
// Byte-in / block-out bus of the DES input stage.
// slave is the stage's view, master is the driver/consumer view.
interface des_in_stage_if;
  import des_pkg::*;

  logic [BYTE_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [KEY_W-1:0]  key_in;
  logic              key_load;
  logic [BLK_W-1:0]  m_block;
  logic [RKEY_W-1:0] m_key;
  logic              m_valid;
  logic              m_ready;
  logic [BCNT_W-1:0] blk_cnt;

  modport slave (
    input  s_data, s_valid, key_in, key_load, m_ready,
    output s_ready, m_block, m_key, m_valid, blk_cnt
  );

  modport master (
    output s_data, s_valid, key_in, key_load, m_ready,
    input  s_ready, m_block, m_key, m_valid, blk_cnt
  );

endinterface

// File: rtl/des_perm.sv
// Pure bit-permutation: output bit k (MSB first) takes input position TABLE[k],
// where position 1 is the input MSB.
module des_perm
  import des_pkg::*;
#(
  parameter int unsigned                       IN_W  = 64,
  parameter int unsigned                       OUT_W = 64,
  parameter logic [OUT_W*TBL_ENT_W-1:0]        TABLE = '0
) (
  input  logic [IN_W-1:0]  i_in,
  output logic [OUT_W-1:0] o_out
);

  for (genvar g = 0; g < int'(OUT_W); g++) begin : g_bit
    localparam int unsigned SRC = 32'(TABLE[(OUT_W-1-g)*TBL_ENT_W +: TBL_ENT_W]);
    assign o_out[OUT_W-1-g] = i_in[IN_W-SRC];
  end

  // Tables that drop bits (PC-1 parity) leave some inputs unread
  logic w_unused;
  assign w_unused = ^i_in;

endmodule

// File: rtl/des_in_stage.sv
// DES input stage: assembles bytes into 64-bit blocks, applies IP to the block and
// PC-1 to the key snapshot, and hands {block,key} to the core through an output register.
module des_in_stage
  import des_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  des_in_stage_if.slave bus
);

  logic [ST_W-1:0]   r_state,   w_state_nxt;
  logic [CNT_W-1:0]  r_cnt,     w_cnt_nxt;
  logic [BLK_W-1:0]  r_asm,     w_asm_nxt;
  logic [KEY_W-1:0]  r_key,     w_key_nxt;
  des_out_t          r_out,     w_out_nxt;
  logic              r_m_valid, w_m_valid_nxt;
  logic              r_s_ready, w_s_ready_nxt;
  logic [BCNT_W-1:0] r_blk_cnt, w_blk_cnt_nxt;

  logic              w_acc;
  logic              w_take;
  logic              w_load;
  logic [KEY_W-1:0]  w_key_sel;
  logic [BLK_W-1:0]  w_ip;
  logic [RKEY_W-1:0] w_pc1;

  assign w_acc  = bus.s_valid & r_s_ready;
  assign w_take = r_m_valid & bus.m_ready;
  // Full block moves out whenever the output register is empty or draining this cycle
  assign w_load = (r_state == ST_FULL) & (~r_m_valid | bus.m_ready);
  // A key strobe coinciding with the load wins over the stored key
  assign w_key_sel = bus.key_load ? bus.key_in : r_key;

  des_perm #(
    .IN_W  (BLK_W),
    .OUT_W (BLK_W),
    .TABLE (IP_TABLE)
  ) u_ip (
    .i_in  (r_asm),
    .o_out (w_ip)
  );

  des_perm #(
    .IN_W  (KEY_W),
    .OUT_W (RKEY_W),
    .TABLE (PC1_TABLE)
  ) u_pc1 (
    .i_in  (w_key_sel),
    .o_out (w_pc1)
  );

  // Next-state and registered-output logic
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_asm_nxt     = r_asm;
    w_key_nxt     = r_key;
    w_out_nxt     = r_out;
    w_m_valid_nxt = r_m_valid;
    w_blk_cnt_nxt = r_blk_cnt;
    w_s_ready_nxt = 1'b0;

    if (bus.key_load) begin
      w_key_nxt = bus.key_in;
    end

    case (r_state)
      ST_IDLE, ST_FILL: begin
        if (w_acc) begin
          w_asm_nxt   = {r_asm[BLK_W-BYTE_W-1:0], bus.s_data};
          w_cnt_nxt   = r_cnt + CNT_W'(1);
          w_state_nxt = (r_cnt == CNT_W'(BYTES_PER_BLK - 1)) ? ST_FULL : ST_FILL;
        end
      end
      ST_FULL: begin
        if (w_load) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    if (w_load) begin
      w_out_nxt.blk = w_ip;
      w_out_nxt.key = w_pc1;
      w_m_valid_nxt = 1'b1;
    end else if (w_take) begin
      w_m_valid_nxt = 1'b0;
    end

    if (w_take) begin
      w_blk_cnt_nxt = r_blk_cnt + BCNT_W'(1);
    end

    w_s_ready_nxt = (w_state_nxt != ST_FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_asm     <= '0;
      r_key     <= '0;
      r_out     <= '0;
      r_m_valid <= 1'b0;
      r_s_ready <= 1'b0;
      r_blk_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_asm     <= w_asm_nxt;
      r_key     <= w_key_nxt;
      r_out     <= w_out_nxt;
      r_m_valid <= w_m_valid_nxt;
      r_s_ready <= w_s_ready_nxt;
      r_blk_cnt <= w_blk_cnt_nxt;
    end
  end

  assign bus.s_ready = r_s_ready;
  assign bus.m_block = r_out.blk;
  assign bus.m_key   = r_out.key;
  assign bus.m_valid = r_m_valid;
  assign bus.blk_cnt = r_blk_cnt;

endmodule

// File: tb/tb_des_in_stage.sv
// Directed and random-stall checks of des_in_stage; inputs driven and outputs
// sampled on the falling edge.
module tb_des_in_stage;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  des_in_stage_if bus ();
  des_in_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int compared   = 0;
  int mismatched = 0;

  localparam int IP_T [64] = '{
    58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
    62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
    57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
    61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int PC1_T [56] = '{
    57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
    10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
    63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
    14,6,61,53,45,37,29, 21,13,5,28,20,12,4};

  localparam logic [63:0] K1     = 64'h133457799BBCDFF1;
  localparam logic [55:0] K1_PC1 = 56'hF0CCAAF556678F;
  localparam logic [63:0] K2     = 64'h0E329232EA6D0D73;
  localparam logic [55:0] K2_PC1 = 56'h14B0BA89F6171E;
  localparam logic [63:0] B0     = 64'h0123456789ABCDEF;
  localparam logic [63:0] B0_IP  = 64'hCC00CCFFF0AAF0AA;

  function automatic logic [63:0] ref_ip(input logic [63:0] d);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) r[63-i] = d[64-IP_T[i]];
    return r;
  endfunction

  function automatic logic [55:0] ref_pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1_T[i]];
    return r;
  endfunction

  // Presents one byte and returns on the falling edge after it was accepted
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.s_data  = b;
    bus.s_valid = 1'b1;
    while (!bus.s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      compared++; mismatched++;
      $display("FAIL send_byte_timeout got s_ready=%0b exp=1 within 50 cycles", bus.s_ready);
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  task automatic send_block(input logic [63:0] b);
    for (int i = 0; i < 8; i++) send_byte(b[63-8*i -: 8]);
  endtask

  task automatic load_key(input logic [63:0] k);
    bus.key_in   = k;
    bus.key_load = 1'b1;
    @(negedge clk);
    bus.key_load = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    compared++; if (bus.s_ready !== 1'b0) begin mismatched++; $display("FAIL rst_s_ready got=%0b exp=0", bus.s_ready); end
    compared++; if (bus.m_valid !== 1'b0) begin mismatched++; $display("FAIL rst_m_valid got=%0b exp=0", bus.m_valid); end
    compared++; if (bus.blk_cnt !== 16'h0) begin mismatched++; $display("FAIL rst_blk_cnt got=%0h exp=0", bus.blk_cnt); end
    compared++; if (bus.m_key !== 56'h0) begin mismatched++; $display("FAIL rst_m_key got=%0h exp=0", bus.m_key); end
    compared++; if (bus.m_block !== 64'h0) begin mismatched++; $display("FAIL rst_m_block got=%0h exp=0", bus.m_block); end
    rst_n = 1'b1;
    @(negedge clk);
    compared++; if (bus.s_ready !== 1'b1) begin mismatched++; $display("FAIL rel_s_ready got=%0b exp=1", bus.s_ready); end
    compared++; if (bus.m_valid !== 1'b0) begin mismatched++; $display("FAIL rel_m_valid got=%0b exp=0", bus.m_valid); end
  endtask

  task automatic test_vector();
    bus.m_ready = 1'b1;
    load_key(K1);
    send_block(B0);
    compared++; if (bus.m_valid !== 1'b0) begin mismatched++; $display("FAIL vec_lat_early got=%0b exp=0", bus.m_valid); end
    compared++; if (bus.s_ready !== 1'b0) begin mismatched++; $display("FAIL vec_full_s_ready got=%0b exp=0", bus.s_ready); end
    @(negedge clk);
    compared++; if (bus.m_valid !== 1'b1) begin mismatched++; $display("FAIL vec_m_valid got=%0b exp=1", bus.m_valid); end
    compared++; if (bus.m_block !== B0_IP) begin mismatched++; $display("FAIL vec_m_block got=%h exp=%h", bus.m_block, B0_IP); end
    compared++; if (bus.m_key !== K1_PC1) begin mismatched++; $display("FAIL vec_m_key got=%h exp=%h", bus.m_key, K1_PC1); end
    compared++; if (bus.s_ready !== 1'b1) begin mismatched++; $display("FAIL vec_s_ready_back got=%0b exp=1", bus.s_ready); end
    @(negedge clk);
    compared++; if (bus.blk_cnt !== 16'd1) begin mismatched++; $display("FAIL vec_blk_cnt got=%0d exp=1", bus.blk_cnt); end
    compared++; if (bus.m_valid !== 1'b0) begin mismatched++; $display("FAIL vec_m_valid_drop got=%0b exp=0", bus.m_valid); end
  endtask

  task automatic test_backpressure();
    logic [63:0] b1, b2, b3;
    b1 = 64'h1122334455667788;
    b2 = 64'h99AABBCCDDEEFF00;
    b3 = 64'hA5A55A5A0F0FF0F0;
    bus.m_ready = 1'b0;
    send_block(b1);
    send_block(b2);
    compared++; if (bus.s_ready !== 1'b0) begin mismatched++; $display("FAIL bp_s_ready got=%0b exp=0", bus.s_ready); end
    compared++; if (bus.m_valid !== 1'b1) begin mismatched++; $display("FAIL bp_m_valid got=%0b exp=1", bus.m_valid); end
    repeat (3) @(negedge clk);
    compared++; if (bus.s_ready !== 1'b0) begin mismatched++; $display("FAIL bp_hold_s_ready got=%0b exp=0", bus.s_ready); end
    compared++; if (bus.m_block !== ref_ip(b1)) begin mismatched++; $display("FAIL bp_hold_blk1 got=%h exp=%h", bus.m_block, ref_ip(b1)); end
    compared++; if (bus.blk_cnt !== 16'd1) begin mismatched++; $display("FAIL bp_hold_cnt got=%0d exp=1", bus.blk_cnt); end
    bus.m_ready = 1'b1;
    @(negedge clk);
    compared++; if (bus.m_valid !== 1'b1) begin mismatched++; $display("FAIL bp_b2b_valid got=%0b exp=1", bus.m_valid); end
    compared++; if (bus.m_block !== ref_ip(b2)) begin mismatched++; $display("FAIL bp_blk2 got=%h exp=%h", bus.m_block, ref_ip(b2)); end
    compared++; if (bus.blk_cnt !== 16'd2) begin mismatched++; $display("FAIL bp_cnt2 got=%0d exp=2", bus.blk_cnt); end
    compared++; if (bus.s_ready !== 1'b1) begin mismatched++; $display("FAIL bp_s_ready_free got=%0b exp=1", bus.s_ready); end
    @(negedge clk);
    compared++; if (bus.m_valid !== 1'b0) begin mismatched++; $display("FAIL bp_drain_valid got=%0b exp=0", bus.m_valid); end
    compared++; if (bus.blk_cnt !== 16'd3) begin mismatched++; $display("FAIL bp_cnt3 got=%0d exp=3", bus.blk_cnt); end
    send_block(b3);
    @(negedge clk);
    compared++; if (bus.m_block !== ref_ip(b3)) begin mismatched++; $display("FAIL bp_blk3 got=%h exp=%h", bus.m_block, ref_ip(b3)); end
    compared++; if (bus.m_key !== K1_PC1) begin mismatched++; $display("FAIL bp_key3 got=%h exp=%h", bus.m_key, K1_PC1); end
    @(negedge clk);
    compared++; if (bus.blk_cnt !== 16'd4) begin mismatched++; $display("FAIL bp_cnt4 got=%0d exp=4", bus.blk_cnt); end
  endtask

  task automatic test_key_race();
    logic [63:0] ba;
    ba = 64'hFEDCBA9876543210;
    bus.m_ready = 1'b0;
    send_block(ba);
    @(negedge clk);
    load_key(64'h0);
    compared++; if (bus.m_key !== K1_PC1) begin mismatched++; $display("FAIL kr_pending_key got=%h exp=%h", bus.m_key, K1_PC1); end
    compared++; if (bus.m_block !== ref_ip(ba)) begin mismatched++; $display("FAIL kr_pending_blk got=%h exp=%h", bus.m_block, ref_ip(ba)); end
    send_block(B0);
    compared++; if (bus.m_key !== K1_PC1) begin mismatched++; $display("FAIL kr_pending_key2 got=%h exp=%h", bus.m_key, K1_PC1); end
    bus.m_ready  = 1'b1;
    bus.key_in   = K2;
    bus.key_load = 1'b1;
    @(negedge clk);
    bus.key_load = 1'b0;
    compared++; if (bus.m_valid !== 1'b1) begin mismatched++; $display("FAIL kr_valid got=%0b exp=1", bus.m_valid); end
    compared++; if (bus.m_block !== B0_IP) begin mismatched++; $display("FAIL kr_blk got=%h exp=%h", bus.m_block, B0_IP); end
    compared++; if (bus.m_key !== K2_PC1) begin mismatched++; $display("FAIL kr_new_key got=%h exp=%h", bus.m_key, K2_PC1); end
    compared++; if (bus.blk_cnt !== 16'd5) begin mismatched++; $display("FAIL kr_cnt5 got=%0d exp=5", bus.blk_cnt); end
    @(negedge clk);
    compared++; if (bus.blk_cnt !== 16'd6) begin mismatched++; $display("FAIL kr_cnt6 got=%0d exp=6", bus.blk_cnt); end
  endtask

  task automatic test_parity();
    bus.m_ready = 1'b1;
    load_key(64'h0F339333EB6C0C72);
    send_block(B0);
    @(negedge clk);
    compared++; if (bus.m_key !== K2_PC1) begin mismatched++; $display("FAIL par_key got=%h exp=%h", bus.m_key, K2_PC1); end
    compared++; if (bus.m_block !== B0_IP) begin mismatched++; $display("FAIL par_blk got=%h exp=%h", bus.m_block, B0_IP); end
    @(negedge clk);
    compared++; if (bus.blk_cnt !== 16'd7) begin mismatched++; $display("FAIL par_cnt got=%0d exp=7", bus.blk_cnt); end
  endtask

  task automatic test_reset_mid();
    int seen;
    bus.m_ready = 1'b0;
    send_block(64'h1111111111111111);
    for (int i = 0; i < 5; i++) send_byte(8'h22 + 8'(i));
    rst_n = 1'b0;
    bus.m_ready = 1'b1;
    @(negedge clk);
    compared++; if (bus.m_valid !== 1'b0) begin mismatched++; $display("FAIL rm_valid got=%0b exp=0", bus.m_valid); end
    compared++; if (bus.blk_cnt !== 16'd0) begin mismatched++; $display("FAIL rm_cnt got=%0d exp=0", bus.blk_cnt); end
    compared++; if (bus.s_ready !== 1'b0) begin mismatched++; $display("FAIL rm_s_ready got=%0b exp=0", bus.s_ready); end
    rst_n = 1'b1;
    @(negedge clk);
    load_key(K1);
    send_block(B0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.m_valid) begin
        seen++;
        compared++; if (bus.m_block !== B0_IP) begin mismatched++; $display("FAIL rm_blk got=%h exp=%h", bus.m_block, B0_IP); end
      end
      @(negedge clk);
    end
    compared++; if (seen !== 1) begin mismatched++; $display("FAIL rm_nblocks got=%0d exp=1", seen); end
    compared++; if (bus.blk_cnt !== 16'd1) begin mismatched++; $display("FAIL rm_cnt_after got=%0d exp=1", bus.blk_cnt); end
  endtask

  task automatic test_wrap();
    logic [63:0] bx;
    bx = 64'h0F1E2D3C4B5A6978;
    force dut.r_blk_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.r_blk_cnt;
    bus.m_ready = 1'b1;
    send_block(B0);
    @(negedge clk);
    compared++; if (bus.blk_cnt !== 16'hFFFE) begin mismatched++; $display("FAIL wr_pre got=%h exp=fffe", bus.blk_cnt); end
    @(negedge clk);
    compared++; if (bus.blk_cnt !== 16'hFFFF) begin mismatched++; $display("FAIL wr_ffff got=%h exp=ffff", bus.blk_cnt); end
    send_block(bx);
    @(negedge clk);
    compared++; if (bus.m_block !== ref_ip(bx)) begin mismatched++; $display("FAIL wr_blk got=%h exp=%h", bus.m_block, ref_ip(bx)); end
    @(negedge clk);
    compared++; if (bus.blk_cnt !== 16'h0000) begin mismatched++; $display("FAIL wr_zero got=%h exp=0000", bus.blk_cnt); end
    compared++; if (bus.m_valid !== 1'b0) begin mismatched++; $display("FAIL wr_valid got=%0b exp=0", bus.m_valid); end
  endtask

  task automatic test_random();
    logic [63:0] asm_r, key_r, exp_b;
    logic [63:0] exp_q [$];
    logic [55:0] exp_k;
    int nacc, got, cyc;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    key_r = {$urandom, $urandom};
    exp_k = ref_pc1(key_r);
    load_key(key_r);
    asm_r = '0; nacc = 0; got = 0; cyc = 0;
    while (got < 1000 && cyc < 40000) begin
      bus.s_valid = (nacc < 8000) && ($urandom_range(0, 3) != 0);
      bus.s_data  = 8'($urandom);
      bus.m_ready = ($urandom_range(0, 2) != 0);
      if (bus.s_valid && bus.s_ready) begin
        asm_r = {asm_r[55:0], bus.s_data};
        nacc++;
        if (nacc % 8 == 0) exp_q.push_back(ref_ip(asm_r));
      end
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL rnd_extra got block %h exp none", bus.m_block);
        end else begin
          exp_b = exp_q.pop_front();
          compared++; if (bus.m_block !== exp_b) begin mismatched++; $display("FAIL rnd_blk[%0d] got=%h exp=%h", got, bus.m_block, exp_b); end
          compared++; if (bus.m_key !== exp_k) begin mismatched++; $display("FAIL rnd_key[%0d] got=%h exp=%h", got, bus.m_key, exp_k); end
        end
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.s_valid = 1'b0;
    compared++; if (got !== 1000) begin mismatched++; $display("FAIL rnd_count got=%0d exp=1000", got); end
    compared++; if (exp_q.size() !== 0) begin mismatched++; $display("FAIL rnd_left got=%0d exp=0", exp_q.size()); end
    compared++; if (bus.blk_cnt !== 16'd1000) begin mismatched++; $display("FAIL rnd_blk_cnt got=%0d exp=1000", bus.blk_cnt); end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    bus.s_data   = '0;
    bus.s_valid  = 1'b0;
    bus.key_in   = '0;
    bus.key_load = 1'b0;
    bus.m_ready  = 1'b0;
    test_reset();
    test_vector();
    test_backpressure();
    test_key_race();
    test_parity();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
